fas_peak_analyzer: RTL and testbench
====================================

Name: fas_peak_analyzer

Overview:
- Consumes the 16-bin FFT frame emitted by the FAS FFT stage (`fft_valid` plus `fft_d0`..`fft_d15`).
- Computes a magnitude per bin serially, one bin per cycle.
- Reports the index of the strongest bin on `freq` with a one-cycle `done` pulse.
- Sits downstream of the FFT core, is the reader side of the FFT output interface, and drives the analysis-stage outputs.

Parameters:
- DW, 16, width of each real/imag component (signed, 8 integer + 8 fraction).
- MW, 2*DW, magnitude accumulator width (unsigned).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-low.
- `fft_valid`  in  1  one-cycle strobe: all 16 bin words are valid this cycle.
- `fft_d0`..`fft_d15`  in  32 each  bin k: real in [31:16], imag in [15:0], both two's complement.
- `busy`  out  1  high while a frame is held in the work bank (CALC state).
- `done`  out  1  one-cycle pulse: `freq` and `peak_mag` are valid.
- `freq`  out  4  index of max-magnitude bin; held until the next `done`.
- `peak_mag`  out  MW  magnitude of the winning bin; held with `freq`.
- `overflow`  out  1  sticky: a frame was dropped.

Behaviour:
- Reset (`rst`=0 sampled at a rising edge, any state): `busy`=0, `done`=0, `freq`=0, `peak_mag`=0, `overflow`=0; pending buffer emptied; state=IDLE.
- Storage: work bank (16x32) and a one-deep pending bank (16x32 plus `pend_v` flag).
- IDLE: on `fft_valid`=1, latch all 16 words into the work bank; bin counter=0; best_mag=0; best_idx=0; go to CALC.
- CALC: one bin per cycle, bin counter 0..15.
  - mag = r*r + i*i, computed signed and the result treated as unsigned MW bits.
  - Maximum is 2*(2^15)^2 = 2^31, which fits in 32 bits; no saturation is needed.
  - Update best when mag > best_mag (strict). Ties therefore keep the lowest index.
  - Bin 0 always loads best, including when mag=0.
- After bin 15 is processed:
  - Register `freq`=best_idx and `peak_mag`=best_mag; pulse `done` for exactly one cycle.
  - If `pend_v`: move the pending bank into the work bank, clear `pend_v`, reset counter and best, and stay in CALC (`busy` stays 1).
  - Otherwise go to IDLE.
- Latency: `fft_valid` sampled at edge E0 → `done` high in the cycle after edge E0+16 (17 edges inclusive). Back-to-back frames produce `done` every 16 cycles.
- `fft_valid` during CALC:
  - If `pend_v`=0: latch into the pending bank and set `pend_v`.
  - If `pend_v`=1: drop the new frame and set `overflow`. The pending frame is kept, not overwritten.
- `fft_valid` on the final CALC cycle (bin 15) with `pend_v`=0: the new frame goes to pending, then moves to work at the same edge, with no loss.
- `fft_valid` on that same final cycle with `pend_v`=1: the pending frame moves to work and the new frame enters pending. No drop occurs because a slot frees on that edge.
- `busy` = (state==CALC). `overflow` clears only on reset.

Optional Feature:
- Macro: `FAS_MAG_L1_EN`.
- Defined: mag = |r| + |i| (DW+1 bits, zero-extended to MW); no multipliers. Same tie/compare rules.
  - |-32768| = 32768, computed without overflow in DW+1 bits.
- Undefined: squared magnitude as above.

Test Plan:
- Reset: hold `rst`=0 two cycles with `fft_valid`=1 → `busy`=0, `done`=0, `freq`=0, `peak_mag`=0, `overflow`=0.
- Single frame: bin5={16'h0300,16'h0400}, others 0 → `done` at edge E0+16 only, `freq`=5, `peak_mag`=32'h0019_0000 (L1 build: 32'h0000_0700).
- Tie: bins 3 and 9 = {16'h0100,16'h0000}, others 0 → `freq`=3, `peak_mag`=32'h0001_0000.
- Signedness: bin12={16'h8000,0}, bin1={16'h7FFF,16'h7FFF} → `freq`=1, `peak_mag`=32'h7FFE_0002. Bin12 magnitude is 32'h4000_0000.
- Buffering:
  - Frames A (peak 2), B (peak 7), C (peak 11) at E0, E0+3, E0+5.
  - Required: `done`/`freq`=2 at E0+16, `done`/`freq`=7 at E0+32.
  - Required: C dropped, `overflow`=1 from E0+5 onward, `busy` low after E0+32.
- Reset mid-operation: frame at E0, second frame pending, `rst`=0 at E0+8 for one cycle → no `done` ever pulses, outputs zero, IDLE. A fresh frame afterwards completes normally in 17 edges.

Source files
------------

// File: rtl/fas_peak_analyzer.sv
// FAS peak analyzer: serially scans a 16-bin FFT frame and reports the strongest bin.
// Build option FAS_MAG_L1_EN selects |r|+|i| magnitude instead of r*r+i*i.
module fas_peak_analyzer #(
   parameter int DW = 16,
   parameter int MW = 2*DW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fft_valid,
   input  logic [2*DW-1:0] fft_d0,
   input  logic [2*DW-1:0] fft_d1,
   input  logic [2*DW-1:0] fft_d2,
   input  logic [2*DW-1:0] fft_d3,
   input  logic [2*DW-1:0] fft_d4,
   input  logic [2*DW-1:0] fft_d5,
   input  logic [2*DW-1:0] fft_d6,
   input  logic [2*DW-1:0] fft_d7,
   input  logic [2*DW-1:0] fft_d8,
   input  logic [2*DW-1:0] fft_d9,
   input  logic [2*DW-1:0] fft_d10,
   input  logic [2*DW-1:0] fft_d11,
   input  logic [2*DW-1:0] fft_d12,
   input  logic [2*DW-1:0] fft_d13,
   input  logic [2*DW-1:0] fft_d14,
   input  logic [2*DW-1:0] fft_d15,
   output logic            busy,
   output logic            done,
   output logic [3:0]      freq,
   output logic [MW-1:0]   peak_mag,
   output logic            overflow
);

   typedef enum logic [0:0] {S_IDLE, S_CALC} state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [2*DW-1:0]   w_in   [16];
   logic [2*DW-1:0]   r_work [16];
   logic [2*DW-1:0]   r_pend [16];
   logic              r_pend_v;
   logic [3:0]        r_cnt;
   logic [MW-1:0]     r_best_mag;
   logic [3:0]        r_best_idx;
   logic              r_done;
   logic [3:0]        r_freq;
   logic [MW-1:0]     r_peak;
   logic              r_ovf;

   logic              w_last;
   logic              w_load_work_in;
   logic              w_load_work_pend;
   logic              w_load_pend_in;
   logic              w_drop;
   logic              w_restart;
   logic              w_pend_v_nxt;

   logic [2*DW-1:0]   w_bin;
   logic signed [DW-1:0] w_re;
   logic signed [DW-1:0] w_im;
   logic [MW-1:0]     w_mag;
   logic              w_better;
   logic [MW-1:0]     w_best_mag_nxt;
   logic [3:0]        w_best_idx_nxt;

   assign w_in[0]  = fft_d0;   assign w_in[1]  = fft_d1;
   assign w_in[2]  = fft_d2;   assign w_in[3]  = fft_d3;
   assign w_in[4]  = fft_d4;   assign w_in[5]  = fft_d5;
   assign w_in[6]  = fft_d6;   assign w_in[7]  = fft_d7;
   assign w_in[8]  = fft_d8;   assign w_in[9]  = fft_d9;
   assign w_in[10] = fft_d10;  assign w_in[11] = fft_d11;
   assign w_in[12] = fft_d12;  assign w_in[13] = fft_d13;
   assign w_in[14] = fft_d14;  assign w_in[15] = fft_d15;

   // ---------------- magnitude of the current bin ----------------
   assign w_bin = r_work[r_cnt];
   assign w_re  = w_bin[2*DW-1:DW];
   assign w_im  = w_bin[DW-1:0];

`ifdef FAS_MAG_L1_EN
   logic [DW:0] w_re_ext;
   logic [DW:0] w_im_ext;
   logic [DW:0] w_abs_re;
   logic [DW:0] w_abs_im;

   // One extra bit keeps |-2^(DW-1)| and the sum exact.
   assign w_re_ext = {w_re[DW-1], w_re};
   assign w_im_ext = {w_im[DW-1], w_im};
   assign w_abs_re = w_re[DW-1] ? (~w_re_ext + (DW+1)'(1)) : w_re_ext;
   assign w_abs_im = w_im[DW-1] ? (~w_im_ext + (DW+1)'(1)) : w_im_ext;
   assign w_mag    = MW'(w_abs_re + w_abs_im);
`else
   logic signed [2*DW-1:0] w_re_x;
   logic signed [2*DW-1:0] w_im_x;
   logic signed [2*DW-1:0] w_re_sq;
   logic signed [2*DW-1:0] w_im_sq;

   assign w_re_x  = (2*DW)'(w_re);
   assign w_im_x  = (2*DW)'(w_im);
   assign w_re_sq = w_re_x * w_re_x;
   assign w_im_sq = w_im_x * w_im_x;
   // Squares are non-negative; summing unsigned holds the 2^31 corner case.
   assign w_mag   = MW'($unsigned(w_re_sq)) + MW'($unsigned(w_im_sq));
`endif

   assign w_better       = (r_cnt == 4'd0) || (w_mag > r_best_mag);
   assign w_best_mag_nxt = w_better ? w_mag : r_best_mag;
   assign w_best_idx_nxt = w_better ? r_cnt : r_best_idx;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_last           = 1'b0;
      w_load_work_in   = 1'b0;
      w_load_work_pend = 1'b0;
      w_load_pend_in   = 1'b0;
      w_drop           = 1'b0;
      w_restart        = 1'b0;
      w_pend_v_nxt     = r_pend_v;
      unique case (r_state)
         S_IDLE: begin
            if (fft_valid) begin
               w_load_work_in = 1'b1;
               w_restart      = 1'b1;
               w_state_nxt    = S_CALC;
            end
         end
         S_CALC: begin
            w_last = (r_cnt == 4'd15);
            if (w_last) begin
               // A slot frees on this edge, so a new frame is never dropped here.
               if (r_pend_v) begin
                  w_load_work_pend = 1'b1;
                  w_restart        = 1'b1;
                  w_load_pend_in   = fft_valid;
                  w_pend_v_nxt     = fft_valid;
               end else if (fft_valid) begin
                  w_load_work_in   = 1'b1;
                  w_restart        = 1'b1;
               end else begin
                  w_state_nxt      = S_IDLE;
               end
            end else if (fft_valid) begin
               if (r_pend_v) begin
                  w_drop         = 1'b1;
               end else begin
                  w_load_pend_in = 1'b1;
                  w_pend_v_nxt   = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- frame storage ----------------
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 16; i++) begin
         if (w_load_work_in)        r_work[i] <= w_in[i];
         else if (w_load_work_pend) r_work[i] <= r_pend[i];
         if (w_load_pend_in)        r_pend[i] <= w_in[i];
      end
   end

   // ---------------- scan / result registers ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pend_v   <= 1'b0;
         r_cnt      <= '0;
         r_best_mag <= '0;
         r_best_idx <= '0;
         r_done     <= 1'b0;
         r_freq     <= '0;
         r_peak     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_pend_v <= w_pend_v_nxt;
         if (w_drop) r_ovf <= 1'b1;
         if (r_state == S_CALC) begin
            r_cnt      <= r_cnt + 4'd1;
            r_best_mag <= w_best_mag_nxt;
            r_best_idx <= w_best_idx_nxt;
            if (w_last) begin
               r_freq <= w_best_idx_nxt;
               r_peak <= w_best_mag_nxt;
               r_done <= 1'b1;
            end
         end
         if (w_restart) begin
            r_cnt      <= '0;
            r_best_mag <= '0;
            r_best_idx <= '0;
         end
      end
   end

   assign busy     = (r_state == S_CALC);
   assign done     = r_done;
   assign freq     = r_freq;
   assign peak_mag = r_peak;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_fas_peak_analyzer.sv
// Directed self-checking bench for fas_peak_analyzer (default or FAS_MAG_L1_EN build).
module tb_fas_peak_analyzer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fft_valid;
   logic [31:0] d [16];
   logic        busy;
   logic        done;
   logic [3:0]  freq;
   logic [31:0] peak_mag;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] fr [3][16];
   int          done_cnt;
   int          done_edge [8];
   logic [3:0]  done_freq [8];
   logic [31:0] done_peak [8];
   logic        ovf_h  [64];
   logic        busy_h [64];

`ifdef FAS_MAG_L1_EN
   localparam logic [31:0] EXP_SINGLE = 32'h0000_0700;
   localparam logic [31:0] EXP_UNIT   = 32'h0000_0100;
   localparam logic [31:0] EXP_SIGNED = 32'h0000_FFFE;
   localparam logic [3:0]  EXP_NEG_F  = 4'd2;
   localparam logic [31:0] EXP_NEG_P  = 32'h0000_0600;
`else
   localparam logic [31:0] EXP_SINGLE = 32'h0019_0000;
   localparam logic [31:0] EXP_UNIT   = 32'h0001_0000;
   localparam logic [31:0] EXP_SIGNED = 32'h7FFE_0002;
   localparam logic [3:0]  EXP_NEG_F  = 4'd7;
   localparam logic [31:0] EXP_NEG_P  = 32'h0019_0000;
`endif

   always #5 clk = ~clk;

   fas_peak_analyzer #(.DW(16), .MW(32)) dut (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
      .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
      .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
      .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
      .busy(busy), .done(done), .freq(freq), .peak_mag(peak_mag), .overflow(overflow)
   );

   task automatic clear_frames();
      for (int k = 0; k < 3; k++)
         for (int b = 0; b < 16; b++) fr[k][b] = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0; fft_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // Edge n of the run is E0+n; frames k are strobed at edge tk, reset held low at rst_at.
   task automatic run_sched(input int nedges, input int t0, input int t1, input int t2,
                            input int rst_at);
      done_cnt = 0;
      for (int n = 0; n < nedges; n++) begin
         fft_valid = 1'b0;
         for (int b = 0; b < 16; b++) d[b] = '0;
         if (n == t0) begin
            fft_valid = 1'b1; for (int b = 0; b < 16; b++) d[b] = fr[0][b];
         end else if (n == t1) begin
            fft_valid = 1'b1; for (int b = 0; b < 16; b++) d[b] = fr[1][b];
         end else if (n == t2) begin
            fft_valid = 1'b1; for (int b = 0; b < 16; b++) d[b] = fr[2][b];
         end
         rst = (n == rst_at) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         if (done === 1'b1) begin
            if (done_cnt < 8) begin
               done_edge[done_cnt] = n;
               done_freq[done_cnt] = freq;
               done_peak[done_cnt] = peak_mag;
            end
            done_cnt++;
         end
         ovf_h[n]  = overflow;
         busy_h[n] = busy;
      end
      fft_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; fft_valid = 1'b1;
      for (int b = 0; b < 16; b++) d[b] = 32'h0100_0100;
      @(posedge clk); @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (freq !== 4'd0) begin errors++; $display("FAIL reset_freq got %0d exp 0", freq); end
      checks++; if (peak_mag !== 32'd0) begin errors++; $display("FAIL reset_peak got %h exp 0", peak_mag); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
      rst = 1'b1; fft_valid = 1'b0;
      for (int b = 0; b < 16; b++) d[b] = '0;
   endtask

   task automatic test_single();
      clear_frames();
      fr[0][5] = 32'h0300_0400;
      run_sched(24, 0, -1, -1, -1);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", done_cnt); end
      checks++; if (done_edge[0] !== 16) begin errors++; $display("FAIL single_latency got %0d exp 16", done_edge[0]); end
      checks++; if (done_freq[0] !== 4'd5) begin errors++; $display("FAIL single_freq got %0d exp 5", done_freq[0]); end
      checks++; if (done_peak[0] !== EXP_SINGLE) begin errors++; $display("FAIL single_peak got %h exp %h", done_peak[0], EXP_SINGLE); end
      checks++; if (busy_h[15] !== 1'b1) begin errors++; $display("FAIL single_busy15 got %b exp 1", busy_h[15]); end
      checks++; if (busy_h[16] !== 1'b0) begin errors++; $display("FAIL single_busy16 got %b exp 0", busy_h[16]); end
      checks++; if (freq !== 4'd5) begin errors++; $display("FAIL single_hold got %0d exp 5", freq); end
   endtask

   task automatic test_tie();
      clear_frames();
      fr[0][3] = 32'h0100_0000;
      fr[0][9] = 32'h0100_0000;
      run_sched(20, 0, -1, -1, -1);
      checks++; if (done_freq[0] !== 4'd3) begin errors++; $display("FAIL tie_freq got %0d exp 3", done_freq[0]); end
      checks++; if (done_peak[0] !== EXP_UNIT) begin errors++; $display("FAIL tie_peak got %h exp %h", done_peak[0], EXP_UNIT); end
   endtask

   task automatic test_signed();
      clear_frames();
      fr[0][12] = 32'h8000_0000;
      fr[0][1]  = 32'h7FFF_7FFF;
      run_sched(20, 0, -1, -1, -1);
      checks++; if (done_freq[0] !== 4'd1) begin errors++; $display("FAIL signed_freq got %0d exp 1", done_freq[0]); end
      checks++; if (done_peak[0] !== EXP_SIGNED) begin errors++; $display("FAIL signed_peak got %h exp %h", done_peak[0], EXP_SIGNED); end
   endtask

   task automatic test_negative();
      clear_frames();
      fr[0][2] = 32'h0400_0200;
      fr[0][7] = 32'hFB00_0000;
      run_sched(20, 0, -1, -1, -1);
      checks++; if (done_freq[0] !== EXP_NEG_F) begin errors++; $display("FAIL neg_freq got %0d exp %0d", done_freq[0], EXP_NEG_F); end
      checks++; if (done_peak[0] !== EXP_NEG_P) begin errors++; $display("FAIL neg_peak got %h exp %h", done_peak[0], EXP_NEG_P); end
   endtask

   task automatic test_zero_frame();
      clear_frames();
      run_sched(20, 0, -1, -1, -1);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_count got %0d exp 1", done_cnt); end
      checks++; if (done_freq[0] !== 4'd0) begin errors++; $display("FAIL zero_freq got %0d exp 0", done_freq[0]); end
      checks++; if (done_peak[0] !== 32'd0) begin errors++; $display("FAIL zero_peak got %h exp 0", done_peak[0]); end
   endtask

   task automatic test_buffering();
      do_reset();
      clear_frames();
      fr[0][2]  = 32'h0100_0000;
      fr[1][7]  = 32'h0100_0000;
      fr[2][11] = 32'h0100_0000;
      run_sched(40, 0, 3, 5, -1);
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL buf_count got %0d exp 2", done_cnt); end
      checks++; if (done_edge[0] !== 16 || done_freq[0] !== 4'd2) begin errors++; $display("FAIL buf_first got edge %0d freq %0d exp 16/2", done_edge[0], done_freq[0]); end
      checks++; if (done_edge[1] !== 32 || done_freq[1] !== 4'd7) begin errors++; $display("FAIL buf_second got edge %0d freq %0d exp 32/7", done_edge[1], done_freq[1]); end
      checks++; if (done_peak[1] !== EXP_UNIT) begin errors++; $display("FAIL buf_peak got %h exp %h", done_peak[1], EXP_UNIT); end
      checks++; if (ovf_h[4] !== 1'b0) begin errors++; $display("FAIL buf_ovf4 got %b exp 0", ovf_h[4]); end
      checks++; if (ovf_h[5] !== 1'b1) begin errors++; $display("FAIL buf_ovf5 got %b exp 1", ovf_h[5]); end
      checks++; if (ovf_h[39] !== 1'b1) begin errors++; $display("FAIL buf_ovf_sticky got %b exp 1", ovf_h[39]); end
      checks++; if (busy_h[31] !== 1'b1) begin errors++; $display("FAIL buf_busy31 got %b exp 1", busy_h[31]); end
      checks++; if (busy_h[32] !== 1'b0) begin errors++; $display("FAIL buf_busy32 got %b exp 0", busy_h[32]); end
   endtask

   task automatic test_last_cycle();
      do_reset();
      clear_frames();
      fr[0][6]  = 32'h0100_0000;
      fr[1][10] = 32'h0100_0000;
      run_sched(36, 0, 16, -1, -1);
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL last_count got %0d exp 2", done_cnt); end
      checks++; if (done_edge[1] !== 32 || done_freq[1] !== 4'd10) begin errors++; $display("FAIL last_second got edge %0d freq %0d exp 32/10", done_edge[1], done_freq[1]); end
      checks++; if (busy_h[16] !== 1'b1) begin errors++; $display("FAIL last_busy got %b exp 1", busy_h[16]); end
      checks++; if (ovf_h[35] !== 1'b0) begin errors++; $display("FAIL last_ovf got %b exp 0", ovf_h[35]); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      clear_frames();
      fr[0][4]  = 32'h0100_0000;
      fr[1][9]  = 32'h0100_0000;
      fr[2][13] = 32'h0100_0000;
      run_sched(56, 0, 4, 16, -1);
      checks++; if (done_cnt !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", done_cnt); end
      checks++; if (done_edge[0] !== 16 || done_freq[0] !== 4'd4) begin errors++; $display("FAIL b2b_first got edge %0d freq %0d exp 16/4", done_edge[0], done_freq[0]); end
      checks++; if (done_edge[1] !== 32 || done_freq[1] !== 4'd9) begin errors++; $display("FAIL b2b_second got edge %0d freq %0d exp 32/9", done_edge[1], done_freq[1]); end
      checks++; if (done_edge[2] !== 48 || done_freq[2] !== 4'd13) begin errors++; $display("FAIL b2b_third got edge %0d freq %0d exp 48/13", done_edge[2], done_freq[2]); end
      checks++; if (ovf_h[55] !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", ovf_h[55]); end
      checks++; if (busy_h[47] !== 1'b1 || busy_h[48] !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b%b exp 10", busy_h[47], busy_h[48]); end
   endtask

   task automatic test_reset_mid();
      clear_frames();
      fr[0][3] = 32'h0100_0000;
      fr[1][8] = 32'h0100_0000;
      run_sched(40, 0, 3, -1, 8);
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rmid_done got %0d exp 0", done_cnt); end
      checks++; if (busy_h[8] !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy_h[8]); end
      checks++; if (freq !== 4'd0 || peak_mag !== 32'd0) begin errors++; $display("FAIL rmid_outs got %0d/%h exp 0/0", freq, peak_mag); end
      clear_frames();
      fr[0][14] = 32'h0100_0000;
      run_sched(20, 0, -1, -1, -1);
      checks++; if (done_cnt !== 1 || done_edge[0] !== 16) begin errors++; $display("FAIL rmid_fresh_lat got cnt %0d edge %0d exp 1/16", done_cnt, done_edge[0]); end
      checks++; if (done_freq[0] !== 4'd14) begin errors++; $display("FAIL rmid_fresh_freq got %0d exp 14", done_freq[0]); end
   endtask

   initial begin
      rst = 1'b0;
      fft_valid = 1'b0;
      for (int b = 0; b < 16; b++) d[b] = '0;
      test_reset();
      test_single();
      test_tie();
      test_signed();
      test_negative();
      test_zero_frame();
      test_buffering();
      test_last_cycle();
      test_back_to_back();
      test_single();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
